// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution (sharpen / Gaussian / edge / passthrough) over a valid/ready stream.
// Optional macro CONV_ROUND_EN: Gaussian result rounds half-up instead of truncating.
module conv3x3_stream #(
   parameter int unsigned PIXEL_WIDTH = 8,
   parameter int unsigned MAX_WIDTH   = 640,
   parameter int unsigned ACCW        = PIXEL_WIDTH + 5,
   localparam int unsigned WW         = $clog2(MAX_WIDTH + 1)
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic [WW-1:0]          i_img_width,
   input  logic [1:0]             i_mode,
   input  logic                   i_s_valid,
   output logic                   o_s_ready,
   input  logic [PIXEL_WIDTH-1:0] i_s_data,
   input  logic                   i_s_sof,
   output logic                   o_m_valid,
   input  logic                   i_m_ready,
   output logic [PIXEL_WIDTH-1:0] o_m_data,
   output logic                   o_m_eol
);

   typedef enum logic [1:0] {
      ModeSharpen = 2'd0,
      ModeGauss   = 2'd1,
      ModeEdge    = 2'd2,
      ModePass    = 2'd3
   } mode_e;

   localparam logic signed [ACCW-1:0] PIX_MAX = ACCW'((1 << PIXEL_WIDTH) - 1);
`ifdef CONV_ROUND_EN
   localparam logic signed [ACCW-1:0] GAUSS_RND = ACCW'(8);
`else
   localparam logic signed [ACCW-1:0] GAUSS_RND = '0;
`endif

   logic                   w_en;
   logic                   w_acc;
   logic [WW-1:0]          r_col;
   logic [WW-1:0]          r_width;
   logic [WW-1:0]          w_col;
   logic [WW-1:0]          w_width;
   logic [1:0]             r_row;
   logic [1:0]             w_row;
   logic [1:0]             r_mode;
   logic [1:0]             w_mode;
   logic [WW:0]            w_col_inc;
   logic                   w_wrap;
   logic                   w_win_ok;
   logic [PIXEL_WIDTH-1:0] r_buf0 [MAX_WIDTH];
   logic [PIXEL_WIDTH-1:0] r_buf1 [MAX_WIDTH];
   logic [PIXEL_WIDTH-1:0] w_top;
   logic [PIXEL_WIDTH-1:0] w_mid;
   logic [PIXEL_WIDTH-1:0] r_win [3][3];
   logic                   r_v0;
   logic                   r_eol0;
   mode_e                  r_mode0;
   logic signed [ACCW-1:0] w_p [3][3];
   logic signed [ACCW-1:0] w_c;
   logic signed [ACCW-1:0] w_cross;
   logic signed [ACCW-1:0] w_corner;
   logic signed [ACCW-1:0] w_sum;
   logic signed [ACCW-1:0] r_sum;
   logic                   r_v1;
   logic                   r_eol1;
   logic [PIXEL_WIDTH-1:0] w_sat;

   // One global enable: any output stall freezes every stage and the input.
   assign w_en      = !(o_m_valid && !i_m_ready);
   assign o_s_ready = w_en;
   assign w_acc     = i_s_valid && w_en;

   // An SOF pixel is (row 0, col 0) and already uses the newly presented frame settings.
   always_comb begin
      w_col     = i_s_sof ? '0 : r_col;
      w_row     = i_s_sof ? 2'd0 : r_row;
      w_width   = i_s_sof ? i_img_width : r_width;
      w_mode    = i_s_sof ? i_mode : r_mode;
      w_col_inc = {1'b0, w_col} + (WW+1)'(1);
      w_wrap    = w_col_inc >= {1'b0, w_width};
      w_win_ok  = (w_row == 2'd2) && (w_col >= WW'(2)) && (w_width >= WW'(3));
   end

   assign w_top = r_buf1[w_col];
   assign w_mid = r_buf0[w_col];

   always_ff @(posedge i_clk) begin
      if (w_acc) begin
         r_buf1[w_col] <= w_mid;
         r_buf0[w_col] <= i_s_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_col     <= '0;
         r_row     <= '0;
         r_width   <= '0;
         r_mode    <= '0;
         r_v0      <= 1'b0;
         r_eol0    <= 1'b0;
         r_mode0   <= ModeSharpen;
         r_v1      <= 1'b0;
         r_eol1    <= 1'b0;
         r_sum     <= '0;
         o_m_valid <= 1'b0;
         o_m_data  <= '0;
         o_m_eol   <= 1'b0;
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               r_win[r][c] <= '0;
            end
         end
      end else if (w_en) begin
         if (w_acc) begin
            r_col   <= w_wrap ? '0 : w_col_inc[WW-1:0];
            // Row only needs to distinguish 0, 1 and "2 or more".
            r_row   <= (w_wrap && w_row != 2'd2) ? w_row + 2'd1 : w_row;
            r_width <= w_width;
            r_mode  <= w_mode;
            for (int r = 0; r < 3; r++) begin
               r_win[r][0] <= r_win[r][1];
               r_win[r][1] <= r_win[r][2];
            end
            r_win[0][2] <= w_top;
            r_win[1][2] <= w_mid;
            r_win[2][2] <= i_s_data;
            r_mode0     <= mode_e'(w_mode);
            r_eol0      <= w_wrap;
         end
         r_v0      <= w_acc && w_win_ok;
         r_v1      <= r_v0;
         r_eol1    <= r_eol0;
         r_sum     <= w_sum;
         o_m_valid <= r_v1;
         o_m_eol   <= r_eol1;
         o_m_data  <= w_sat;
      end
   end

   always_comb begin
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            w_p[r][c] = $signed({{(ACCW-PIXEL_WIDTH){1'b0}}, r_win[r][c]});
         end
      end
      w_c      = w_p[1][1];
      w_cross  = w_p[0][1] + w_p[2][1] + w_p[1][0] + w_p[1][2];
      w_corner = w_p[0][0] + w_p[0][2] + w_p[2][0] + w_p[2][2];
      w_sum    = w_c;
      case (r_mode0)
         ModeSharpen: w_sum = (w_c <<< 2) + w_c - w_cross;
         ModeGauss:   w_sum = (w_corner + (w_cross <<< 1) + (w_c <<< 2) + GAUSS_RND) >>> 4;
         ModeEdge:    w_sum = (w_c <<< 3) - w_cross - w_corner;
         ModePass:    w_sum = w_c;
      endcase
   end

   always_comb begin
      if (r_sum[ACCW-1]) begin
         w_sat = '0;
      end else if (r_sum > PIX_MAX) begin
         w_sat = '1;
      end else begin
         w_sat = r_sum[PIXEL_WIDTH-1:0];
      end
   end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Directed self-checking bench for conv3x3_stream with hand-computed expected outputs.
module tb_conv3x3_stream;

   localparam int unsigned PW   = 8;
   localparam int unsigned MAXW = 640;
   localparam int unsigned WW   = $clog2(MAXW + 1);
`ifdef CONV_ROUND_EN
   localparam int RND_EXP = 1;
`else
   localparam int RND_EXP = 0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [WW-1:0] img_width = '0;
   logic [1:0]    mode = '0;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [PW-1:0] s_data = '0;
   logic          s_sof = 1'b0;
   logic          m_valid;
   logic          m_ready = 1'b1;
   logic [PW-1:0] m_data;
   logic          m_eol;

   int            errors = 0;
   int            checks = 0;
   int            sent_cycles = 0;
   logic          tog_en = 1'b0;
   logic [PW-1:0] pix[$];
   logic [PW:0]   exp_q[$];
   logic [PW:0]   q_out[$];
   int            n_rdy_bad = 0;
   int            n_stall = 0;

   conv3x3_stream #(.PIXEL_WIDTH(PW), .MAX_WIDTH(MAXW)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_img_width (img_width),
      .i_mode      (mode),
      .i_s_valid   (s_valid),
      .o_s_ready   (s_ready),
      .i_s_data    (s_data),
      .i_s_sof     (s_sof),
      .o_m_valid   (m_valid),
      .i_m_ready   (m_ready),
      .o_m_data    (m_data),
      .o_m_eol     (m_eol)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      #1;
      m_ready = tog_en ? ~m_ready : 1'b1;
   end

   always @(negedge clk) begin
      if (s_ready !== !(m_valid && !m_ready)) n_rdy_bad++;
      if (m_valid && !m_ready) n_stall++;
      if (rst_n && m_valid && m_ready) q_out.push_back({m_eol, m_data});
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation still running, required to finish");
      $fatal(1);
   end

   task automatic push(input logic [PW-1:0] d, input logic sof);
      int   n;
      logic acc;
      s_data = d; s_sof = sof; s_valid = 1'b1; n = 0;
      do begin
         @(negedge clk);
         acc = s_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!acc && n < 50);
      if (!acc) begin
         checks++; errors++;
         $display("FAIL push_timeout: accepted=%0b required=1", acc);
      end
      s_valid = 1'b0; s_sof = 1'b0;
      sent_cycles += n;
   endtask

   task automatic send_frame(input int w, input logic [1:0] m);
      img_width = WW'(w); mode = m; sent_cycles = 0;
      foreach (pix[i]) push(pix[i], i == 0);
   endtask

   task automatic drain(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      @(negedge clk);
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid: got %0b required 0", m_valid); end
      checks++; if (m_data !== '0) begin errors++; $display("FAIL rst_m_data: got %0d required 0", m_data); end
      checks++; if (m_eol !== 1'b0) begin errors++; $display("FAIL rst_m_eol: got %0b required 0", m_eol); end
      checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_s_ready: got %0b required 1", s_ready); end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL post_rst_s_ready: got %0b required 1", s_ready); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_uniform();
      int base;
      for (int m = 0; m < 4; m++) begin
         pix.delete(); exp_q.delete();
         for (int i = 0; i < 16; i++) pix.push_back(PW'(100));
         for (int i = 0; i < 4; i++) exp_q.push_back({(i % 2 == 1), (m == 2) ? PW'(0) : PW'(100)});
         base = q_out.size();
         send_frame(4, 2'(m));
         drain(8);
         checks++;
         if (q_out.size() - base !== exp_q.size()) begin
            errors++;
            $display("FAIL uniform%0d_count: got %0d required %0d", m, q_out.size() - base, exp_q.size());
         end
         for (int i = 0; i < exp_q.size() && base + i < q_out.size(); i++) begin
            checks++;
            if (q_out[base+i] !== exp_q[i]) begin
               errors++;
               $display("FAIL uniform%0d_out%0d: got eol=%0b data=%0d required eol=%0b data=%0d", m, i,
                        q_out[base+i][PW], q_out[base+i][PW-1:0], exp_q[i][PW], exp_q[i][PW-1:0]);
            end
         end
      end
   endtask

   task automatic test_kernels();
      int t_mode[7] = '{2, 0, 0, 1, 1, 1, 2};
      int t_cen[7]  = '{255, 255, 0, 8, 1, 2, 0};
      int t_bg[7]   = '{0, 0, 255, 0, 0, 0, 255};
      int t_exp[7]  = '{255, 255, 0, 2, 0, RND_EXP, 0};
      int base;
      for (int k = 0; k < 7; k++) begin
         pix.delete();
         for (int i = 0; i < 9; i++) pix.push_back((i == 4) ? PW'(t_cen[k]) : PW'(t_bg[k]));
         base = q_out.size();
         send_frame(3, 2'(t_mode[k]));
         drain(8);
         checks++;
         if (q_out.size() - base !== 1) begin
            errors++;
            $display("FAIL kernel%0d_count: got %0d required 1", k, q_out.size() - base);
         end
         if (q_out.size() > base) begin
            checks++;
            if (q_out[base] !== {1'b1, PW'(t_exp[k])}) begin
               errors++;
               $display("FAIL kernel%0d_out: got eol=%0b data=%0d required eol=1 data=%0d", k,
                        q_out[base][PW], q_out[base][PW-1:0], t_exp[k]);
            end
         end
      end
   endtask

   // Sharpen of p = 100 + 10r + c^2 gives 100 + 10r + c^2 - 2 at each interior centre.
   task automatic test_backpressure();
      int base, stall0, rdy0;
      pix.delete(); exp_q.delete();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 5; c++) pix.push_back(PW'(100 + 10 * r + c * c));
      exp_q.push_back({1'b0, PW'(109)}); exp_q.push_back({1'b0, PW'(112)});
      exp_q.push_back({1'b1, PW'(117)}); exp_q.push_back({1'b0, PW'(119)});
      exp_q.push_back({1'b0, PW'(122)}); exp_q.push_back({1'b1, PW'(127)});
      rdy0 = n_rdy_bad;
      for (int run = 0; run < 2; run++) begin
         stall0 = n_stall;
         tog_en = (run == 1);
         base = q_out.size();
         send_frame(5, 2'd0);
         if (run == 0) begin
            checks++;
            if (sent_cycles !== 20) begin
               errors++; $display("FAIL throughput: got %0d cycles required 20", sent_cycles);
            end
         end
         drain(14);
         tog_en = 1'b0;
         drain(3);
         if (run == 1) begin
            checks++;
            if (!(n_stall > stall0)) begin
               errors++; $display("FAIL bp_stalls: got %0d stall cycles required >0", n_stall - stall0);
            end
         end
         checks++;
         if (q_out.size() - base !== exp_q.size()) begin
            errors++;
            $display("FAIL bp%0d_count: got %0d required %0d", run, q_out.size() - base, exp_q.size());
         end
         for (int i = 0; i < exp_q.size() && base + i < q_out.size(); i++) begin
            checks++;
            if (q_out[base+i] !== exp_q[i]) begin
               errors++;
               $display("FAIL bp%0d_out%0d: got eol=%0b data=%0d required eol=%0b data=%0d", run, i,
                        q_out[base+i][PW], q_out[base+i][PW-1:0], exp_q[i][PW], exp_q[i][PW-1:0]);
            end
         end
      end
      checks++;
      if (n_rdy_bad !== rdy0) begin
         errors++; $display("FAIL s_ready_relation: got %0d violations required 0", n_rdy_bad - rdy0);
      end
   endtask

   task automatic test_reset_mid_frame();
      int base;
      pix.delete();
      for (int i = 0; i < 9; i++) pix.push_back(PW'(i + 1));
      base = q_out.size();
      send_frame(3, 2'd3);
      rst_n = 1'b0;
      @(negedge clk);
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL midrst_m_valid: got %0b required 0", m_valid); end
      @(negedge clk);
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL midrst_m_valid2: got %0b required 0", m_valid); end
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 9; i++) push(PW'(50), 1'b0);
      drain(6);
      checks++;
      if (q_out.size() - base !== 0) begin
         errors++; $display("FAIL stale_outputs: got %0d required 0", q_out.size() - base);
      end
      pix.delete();
      for (int i = 0; i < 9; i++) pix.push_back(PW'(11 * (i + 1)));
      base = q_out.size();
      send_frame(3, 2'd3);
      @(negedge clk);
      @(negedge clk);
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL latency_early: got m_valid=%0b required 0", m_valid); end
      @(negedge clk);
      checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL latency_due: got m_valid=%0b required 1", m_valid); end
      drain(4);
      checks++;
      if (q_out.size() - base !== 1) begin
         errors++; $display("FAIL newframe_count: got %0d required 1", q_out.size() - base);
      end else begin
         checks++;
         if (q_out[base] !== {1'b1, PW'(55)}) begin
            errors++; $display("FAIL newframe_out: got eol=%0b data=%0d required eol=1 data=55",
                               q_out[base][PW], q_out[base][PW-1:0]);
         end
      end
   endtask

   task automatic test_mid_sof();
      int base;
      pix.delete(); exp_q.delete();
      for (int i = 0; i < 10; i++) pix.push_back((i == 4) ? PW'(10) : PW'(0));
      exp_q.push_back({1'b1, PW'(80)}); exp_q.push_back({1'b1, PW'(16)});
      base = q_out.size();
      send_frame(3, 2'd2);
      pix.delete();
      for (int i = 0; i < 9; i++) pix.push_back(PW'(16));
      send_frame(3, 2'd1);
      drain(8);
      checks++;
      if (q_out.size() - base !== exp_q.size()) begin
         errors++; $display("FAIL midsof_count: got %0d required %0d", q_out.size() - base, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && base + i < q_out.size(); i++) begin
         checks++;
         if (q_out[base+i] !== exp_q[i]) begin
            errors++;
            $display("FAIL midsof_out%0d: got eol=%0b data=%0d required eol=%0b data=%0d", i,
                     q_out[base+i][PW], q_out[base+i][PW-1:0], exp_q[i][PW], exp_q[i][PW-1:0]);
         end
      end
   endtask

   task automatic test_narrow();
      int base;
      pix.delete();
      for (int i = 0; i < 8; i++) pix.push_back(PW'(200));
      base = q_out.size();
      send_frame(2, 2'd3);
      drain(8);
      checks++;
      if (q_out.size() - base !== 0) begin
         errors++; $display("FAIL narrow_count: got %0d required 0", q_out.size() - base);
      end
   endtask

   initial begin
      test_reset();
      test_uniform();
      test_kernels();
      test_backpressure();
      test_reset_mid_frame();
      test_mid_sof();
      test_narrow();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/conv3x3_stream.md
# conv3x3_stream

Streaming 3×3 image-kernel convolution engine. It is the parametrised successor of the team's fixed-window convolver. It accepts raster-order single-channel pixels over a valid/ready stream and stores two image rows in internal line buffers. It applies a runtime-selected kernel (sharpen, Gaussian, edge, passthrough) and emits saturated interior pixels on a valid/ready output stream. It sits between the frame source and the output formatter in the image pipeline.

## Interface
- PIXEL_WIDTH, 8, bits per unsigned pixel
- MAX_WIDTH, 640, maximum line length; sets the depth of each line buffer
- ACCW, PIXEL_WIDTH+5, signed accumulator width; must be at least PIXEL_WIDTH+5
- clk  in  1  clock, one pixel per cycle maximum
- rst_n  in  1  asynchronous active-low reset
- img_width  in  $clog2(MAX_WIDTH+1)  active line length; sampled on SOF
- mode  in  2  kernel select: 0 sharpen, 1 Gaussian, 2 edge, 3 passthrough; sampled on SOF
- s_valid  in  1  input pixel valid
- s_ready  out  1  input ready
- s_data  in  PIXEL_WIDTH  input pixel, unsigned
- s_sof  in  1  marks the first pixel of a frame; qualified by s_valid & s_ready
- m_valid  out  1  output pixel valid
- m_ready  in  1  downstream ready
- m_data  out  PIXEL_WIDTH  convolved pixel
- m_eol  out  1  output pixel is the last of its output row

## Operation
- Accept condition: s_valid & s_ready.
- On an accept with s_sof:
  - row and col counters are cleared, so this pixel is (row 0, col 0).
  - img_width and mode are latched into the frame registers.
- Counters:
  - col wraps from img_width-1 to 0.
  - row increments on each col wrap.
  - There is no frame-height input. A frame ends at the next s_sof.
- Line buffers:
  - Two single-port-per-cycle RAMs, MAX_WIDTH deep, indexed by col.
  - On accept, buf1[col] is written with buf0[col], and buf0[col] is written with s_data.
- Window: a 3×3 shift register. Each accept shifts in {buf1[col], buf0[col], s_data} as the right column (top, mid, bottom).
- A window is valid when row ≥ 2 and col ≥ 2. Output frame size is (W-2)×(rows-2).
- If the latched img_width < 3, no outputs are produced.
- Kernels, with pixels zero-extended into ACCW signed and c = centre:
  - sharpen: 5c − (N+S+E+W)
  - Gaussian: (corners + 2·edges + 4c) >>> 4
  - edge: 8c − (sum of the 8 neighbours)
  - passthrough: c
- Saturation: results < 0 become 0; results > 2^PIXEL_WIDTH−1 become 2^PIXEL_WIDTH−1.
- m_eol is set when the window's col = img_width−1.
- A mid-frame s_sof abandons the current frame. Pipeline contents already in flight still drain and are delivered. Line-buffer contents are not cleared, but are never used because of the row < 2 gating.
- img_width > MAX_WIDTH is unsupported; behaviour is undefined.

## Timing
- Pipeline, all stages under one enable en = !(m_valid & !m_ready):
  - S0: accept, window shift, line-buffer write.
  - S1: kernel sum registered.
  - S2: saturation registered into m_data/m_valid.
- s_ready = en. It is combinational from m_valid/m_ready and is not dependent on s_valid.
- Latency: m_valid rises 2 cycles after the accept cycle of a window's bottom-right pixel, with m_ready held high.
- Throughput: 1 pixel/cycle sustained with no backpressure.
- While stalled:
  - m_data, m_eol and all internal stages hold.
  - No line-buffer writes occur.
- Reset values:
  - s_ready=1 once rst_n releases; it is 1 while m_valid=0.
  - m_valid=0, m_data=0, m_eol=0.
  - Counters are 0; frame mode=0 and frame img_width=0, so no outputs are produced until the first SOF.
- Reset asserted mid-frame: all pipeline valids clear immediately. The frame is lost, and the next output requires a new s_sof.

## Configuration
- CONV_ROUND_EN is the single configuration macro.
- Defined: the Gaussian sum gets +8 before >>>4, i.e. round-half-up.
- Undefined: plain truncating >>>4.
- Other kernels are unaffected either way.

## Test plan
- Width 4, 4 rows, all pixels 100, modes 0/1/2/3: 4 outputs each of 100/100/0/100. m_eol is set on the 2nd and 4th outputs.
- Width 3, single 255 at (1,1), others 0, edge mode: one output of 255 (2040 saturated). Same input in sharpen mode gives 255; the inverted image (centre 0, neighbours 255) gives 0 (−1020 clipped).
- Gaussian, centre 8 at (1,1), others 0, width 3: sum 32, output 2. With centre 1 and neighbours 0: sum 4 gives output 0 with or without CONV_ROUND_EN; centre 2 (sum 8) gives output 1 only with CONV_ROUND_EN.
- Width 5 ramp frame with m_ready toggling every other cycle: the output sequence is identical to the m_ready=1 run, and s_ready=0 exactly when m_valid=1 & m_ready=0.
- rst_n pulsed low mid-frame, then a new SOF frame: m_valid=0 during reset, no stale outputs after it, and the new frame's outputs are correct.
- Mid-frame s_sof with mode changed from 2 to 1: in-flight edge outputs (≤2) complete, then the new frame produces Gaussian outputs only after row 2, col 2.
